pmem_rr_arbiter: RTL

- N-channel physical-memory arbiter that sits between the L1 caches (icache, dcache, and future prefetch/victim buffers) and the single shared pmem port.
- Parametrised successor to the two-master fixed-priority arbiter. Generalised to NUM_CH requesters, with selectable round-robin or fixed priority, a registered grant and a one-cycle turnaround state.
- Produces pipe_load, a stall-free indication used to gate the pipeline latch loads.

---
 rtl/pmem_rr_arbiter_pkg.sv | 20 ++
 rtl/pmem_rr_arbiter_rr_pick.sv | 34 +++
 rtl/pmem_rr_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pmem_rr_arbiter_pkg.sv
// Shared types and helpers for the pmem round-robin arbiter.
package pmem_rr_arbiter_pkg;

  // Upper bound on the number of requesting channels.
  localparam int ARB_MAX_CH = 8;

  // Arbiter FSM encoding, kept as plain constants for legacy tool flows.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_BUSY = 2'd1;
  localparam arb_state_t ARB_DONE = 2'd2;

  // (a + b) mod n for operands already below n; avoids a real divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/pmem_rr_arbiter_rr_pick.sv
// Rotating priority picker: first pending index at or after ptr, wrapping.
// Driving ptr with zero turns it into a plain lowest-index-wins encoder.
module pmem_rr_arbiter_rr_pick
  import pmem_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         pending,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [$clog2(NUM_CH)-1:0] winner,
  output logic                      any_valid
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = IDX_W'(wrap_add(int'(ptr), k, NUM_CH));
      if (pending[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmem_rr_arbiter.sv
// N-channel arbiter between the L1 caches and the single shared pmem port.
// Registered grant, one turnaround cycle after every completion.
module pmem_rr_arbiter
  import pmem_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 128,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_read,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH*ADDR_W-1:0]   req_address,
  input  logic [NUM_CH*LINE_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          req_resp,
  output logic [LINE_W-1:0]          req_rdata,
  input  logic                       pmem_resp,
  input  logic [LINE_W-1:0]          pmem_rdata,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       busy,
  output logic                       pipe_load
);

  localparam int IDX_W = $clog2(NUM_CH);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             is_write_q, is_write_d;

  logic [NUM_CH-1:0] pending;
  logic [IDX_W-1:0]  pick_ptr;
  logic [IDX_W-1:0]  winner;
  logic              any_valid;

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [LINE_W-1:0] wdata_arr [NUM_CH];

  assign pending  = req_read | req_write;
  assign pick_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;

  // Unpack the flat per-channel buses so the grant can index them directly.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_arr[i]  = req_address[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*LINE_W +: LINE_W];
  end

  pmem_rr_arbiter_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .pending   (pending),
    .ptr       (pick_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Address and write data come straight from the granted channel; the
  // requester holds them stable for the whole transaction.
  assign busy         = (state_q == ARB_BUSY);
  assign grant_id     = grant_q;
  assign pmem_read    = busy & ~is_write_q;
  assign pmem_write   = busy &  is_write_q;
  assign pmem_address = addr_arr[grant_q];
  assign pmem_wdata   = wdata_arr[grant_q];
  assign req_rdata    = pmem_rdata;
  assign pipe_load    = &(~pending | req_resp);

  // Completion pulse to the granted channel only; stray pmem_resp is dropped.
  always_comb begin
    req_resp = '0;
    if (busy && pmem_resp) req_resp[grant_q] = 1'b1;
  end

  // Grant selection and IDLE -> BUSY -> DONE -> IDLE sequencing.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    is_write_d = is_write_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          grant_d    = winner;
          is_write_d = req_write[winner];  // write wins over a simultaneous read
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (pmem_resp) begin
          state_d = ARB_DONE;
          if (RR_MODE != 0) rr_ptr_d = IDX_W'(wrap_add(int'(grant_q), 1, NUM_CH));
        end
      end
      ARB_DONE: state_d = ARB_IDLE;  // lets the serviced channel deassert
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      is_write_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      is_write_q <= is_write_d;
    end
  end

endmodule
